// File: rtl/program_loader_pkg.sv
// Shared state encoding and header layout for the program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD_I,
        ST_LOAD_D,
        ST_CHK,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_e;

    // Header word: imem word count in the upper half, dmem word count in the lower half.
    localparam int N_I_MSB = 31;
    localparam int N_I_LSB = 16;
    localparam int N_D_MSB = 15;
    localparam int N_D_LSB = 0;

    localparam int DEF_ADDR_STRIDE = 4;

endpackage

// File: rtl/program_loader_if.sv
// Word stream plus imem/dmem external write ports between a host and the program loader.
interface program_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    logic [31:0]       addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;

    logic [31:0]       addr_ext_2;
    logic              wen_ext_2;
    logic              ren_ext_2;
    logic [DATA_W-1:0] wdata_ext_2;

    // The loader consumes the stream and drives both memory ports.
    modport slave (
        input  s_valid, s_data,
        output s_ready,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport master (
        output s_valid, s_data,
        input  s_ready,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

endinterface

// File: rtl/loader_word_counter.sv
// Loadable up/down counter with a terminal-count compare; used for word index and run length.
module loader_word_counter #(
    parameter int W    = 32,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (step_i) begin
            count_d = DOWN ? count_q - W'(1) : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low reset.
module reg_arstn_en #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a header-framed program image into imem/dmem, then runs the cpu for run_len cycles.
// Build option LOADER_CHECKSUM_EN adds a trailer word checked against the sum of header and payload.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IMEM_DEPTH  = 512,
    parameter int DMEM_DEPTH  = 1024,
    parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [31:0]           run_len,
    program_loader_if.slave       bus,
    output logic                  cpu_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_e state_q, state_d;

    logic              hs, start_acc, hdr_hs, hdr_bad;
    logic [15:0]       hdr_n_i, hdr_n_d, n_i_q, n_d_q;
    logic [DATA_W-1:0] hdr_q;
    logic              wr_i, wr_d, idx_load, idx_tc, strobe_pending;
    logic [31:0]       idx_count, idx_term, wr_addr;
    logic              run_go, run_tc;
    logic [31:0]       run_count;

    assign hs        = bus.s_valid && bus.s_ready;
    assign start_acc = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign hdr_hs    = hs && (state_q == ST_HDR);
    assign hdr_n_i   = bus.s_data[N_I_MSB:N_I_LSB];
    assign hdr_n_d   = bus.s_data[N_D_MSB:N_D_LSB];
    assign hdr_bad   = (hdr_n_i > 16'(IMEM_DEPTH)) || (hdr_n_d > 16'(DMEM_DEPTH));

    reg_arstn_en #(.W(DATA_W)) u_hdr (
        .clk(clk), .arst_n(arst_n), .en_i(hdr_hs), .d_i(bus.s_data), .q_o(hdr_q)
    );
    assign n_i_q = hdr_q[N_I_MSB:N_I_LSB];
    assign n_d_q = hdr_q[N_D_MSB:N_D_LSB];

    // Word index restarts at 0 for each memory section.
    assign wr_i     = hs && (state_q == ST_LOAD_I);
    assign wr_d     = hs && (state_q == ST_LOAD_D);
    assign idx_load = hdr_hs || (wr_i && idx_tc);
    assign idx_term = ((state_q == ST_LOAD_I) ? {16'b0, n_i_q} : {16'b0, n_d_q}) - 32'd1;
    assign wr_addr  = idx_count * 32'(ADDR_STRIDE);

    loader_word_counter #(.W(32), .DOWN(1'b0)) u_idx (
        .clk(clk), .arst_n(arst_n), .load_i(idx_load), .load_val_i('0),
        .step_i(wr_i || wr_d), .term_i(idx_term), .count_o(idx_count), .tc_o(idx_tc)
    );

    reg_arstn_en #(.W(1)) u_wen_i (
        .clk(clk), .arst_n(arst_n), .en_i(1'b1), .d_i(wr_i), .q_o(bus.wen_ext)
    );
    reg_arstn_en #(.W(32)) u_addr_i (
        .clk(clk), .arst_n(arst_n), .en_i(wr_i), .d_i(wr_addr), .q_o(bus.addr_ext)
    );
    reg_arstn_en #(.W(DATA_W)) u_data_i (
        .clk(clk), .arst_n(arst_n), .en_i(wr_i), .d_i(bus.s_data), .q_o(bus.wdata_ext)
    );
    reg_arstn_en #(.W(1)) u_wen_d (
        .clk(clk), .arst_n(arst_n), .en_i(1'b1), .d_i(wr_d), .q_o(bus.wen_ext_2)
    );
    reg_arstn_en #(.W(32)) u_addr_d (
        .clk(clk), .arst_n(arst_n), .en_i(wr_d), .d_i(wr_addr), .q_o(bus.addr_ext_2)
    );
    reg_arstn_en #(.W(DATA_W)) u_data_d (
        .clk(clk), .arst_n(arst_n), .en_i(wr_d), .d_i(bus.s_data), .q_o(bus.wdata_ext_2)
    );

    assign bus.ren_ext   = 1'b0;
    assign bus.ren_ext_2 = 1'b0;

    // The final write strobe can still be on the bus in the first RUN cycle; hold the cpu until it clears.
    assign strobe_pending = bus.wen_ext || bus.wen_ext_2;
    assign run_go         = (state_q == ST_RUN) && !strobe_pending;

    loader_word_counter #(.W(32), .DOWN(1'b1)) u_run (
        .clk(clk), .arst_n(arst_n), .load_i(start_acc), .load_val_i(run_len),
        .step_i(run_go && !run_tc), .term_i('0), .count_o(run_count), .tc_o(run_tc)
    );

`ifdef LOADER_CHECKSUM_EN
    localparam state_e PAYLOAD_END = ST_CHK;

    logic [DATA_W-1:0] sum_q, sum_d;
    logic              chk_ok;

    always_comb begin
        sum_d = sum_q;
        if (hdr_hs) begin
            sum_d = bus.s_data;
        end else if (wr_i || wr_d) begin
            sum_d = sum_q + bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chk_ok = (bus.s_data == sum_q);
`else
    localparam state_e PAYLOAD_END = ST_RUN;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_HDR;
            ST_HDR: begin
                if (hs) begin
                    if (hdr_bad)              state_d = ST_ERR;
                    else if (hdr_n_i != '0)   state_d = ST_LOAD_I;
                    else if (hdr_n_d != '0)   state_d = ST_LOAD_D;
                    else                      state_d = PAYLOAD_END;
                end
            end
            ST_LOAD_I: if (hs && idx_tc) state_d = (n_d_q != '0) ? ST_LOAD_D : PAYLOAD_END;
            ST_LOAD_D: if (hs && idx_tc) state_d = PAYLOAD_END;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK:    if (hs) state_d = chk_ok ? ST_RUN : ST_ERR;
`endif
            ST_RUN:    if (run_go && run_tc) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.s_ready = state_q inside {ST_HDR, ST_LOAD_I, ST_LOAD_D, ST_CHK};
    assign cpu_enable  = run_go && (run_count != '0);
    assign busy        = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of load/run sessions plus reset and checksum sequences.
module tb_program_loader;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] run_len;
        bit          gap;
        bit          hdr_ok;
        logic [31:0] trl_xor;
        logic [31:0] seed;
        bit          exp_err;
        int          exp_si;
        int          exp_sd;
        int          exp_en;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [31:0] run_len;
    logic        cpu_enable, busy, done, error;

    program_loader_if #(.DATA_W(32)) bus ();

    program_loader dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .run_len   (run_len),
        .bus       (bus.slave),
        .cpu_enable(cpu_enable),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  en_total = 0;
    int  overlap_total = 0;
    wr_t exp_i[$], exp_d[$], obs_i[$], obs_d[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the memory ports and cpu_enable mid-cycle.
    always @(negedge clk) begin
        if (bus.wen_ext)   obs_i.push_back('{bus.addr_ext, bus.wdata_ext});
        if (bus.wen_ext_2) obs_d.push_back('{bus.addr_ext_2, bus.wdata_ext_2});
        if (cpu_enable) en_total++;
        if (cpu_enable && (bus.wen_ext || bus.wen_ext_2)) overlap_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_word(input logic [31:0] w);
        int budget = 20;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!bus.s_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            check("s_ready_wait", 32'(bus.s_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic compare_writes();
        wr_t o, e;
        check("imem_strobe_count", 32'(obs_i.size()), 32'(exp_i.size()));
        while (obs_i.size() > 0 && exp_i.size() > 0) begin
            o = obs_i.pop_front();
            e = exp_i.pop_front();
            check("imem_addr", o.addr, e.addr);
            check("imem_data", o.data, e.data);
        end
        check("dmem_strobe_count", 32'(obs_d.size()), 32'(exp_d.size()));
        while (obs_d.size() > 0 && exp_d.size() > 0) begin
            o = obs_d.pop_front();
            e = exp_d.pop_front();
            check("dmem_addr", o.addr, e.addr);
            check("dmem_data", o.data, e.data);
        end
        obs_i.delete(); exp_i.delete();
        obs_d.delete(); exp_d.delete();
    endtask

    task automatic run_session(input vec_t v);
        logic [31:0] w, sum;
        int          en_base, cyc;
        en_base = en_total;
        start   = 1'b1;
        run_len = v.run_len;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(v.hdr);
        sum = v.hdr;
        for (int k = 0; k < v.exp_si; k++) begin
            w = v.seed + 32'(k);
            send_word(w);
            exp_i.push_back('{32'(k * 4), w});
            sum += w;
            if (v.gap) begin
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < v.exp_sd; k++) begin
            w = ~v.seed + 32'(k);
            send_word(w);
            exp_d.push_back('{32'(k * 4), w});
            sum += w;
        end
`ifdef LOADER_CHECKSUM_EN
        if (v.hdr_ok) send_word(sum ^ v.trl_xor);
`endif
        cyc = 0;
        while (!(done || error) && cyc < 100 + int'(v.run_len)) begin
            @(negedge clk);
            cyc++;
        end
        check("done", 32'(done), 32'(!v.exp_err));
        check("error", 32'(error), 32'(v.exp_err));
        check("busy_end", 32'(busy), 32'd0);
        check("enable_cycles", 32'(en_total - en_base), 32'(v.exp_en));
        check("ren_tied", 32'({bus.ren_ext, bus.ren_ext_2}), 32'd0);
        if (v.hdr == 32'h0 && v.run_len == 32'h0) check("zero_hdr_latency", 32'(cyc <= 3), 32'd1);
        compare_writes();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [31:0] w1, w2;
        int          cyc;

        tbl[0] = '{32'h0003_0002, 32'd10, 1'b0, 1'b1, 32'h0, 32'h1111_0000, 1'b0, 3, 2, 10};
        tbl[1] = '{32'h0201_0000, 32'd5,  1'b0, 1'b0, 32'h0, 32'h0,         1'b1, 0, 0, 0};
        tbl[2] = '{32'h0000_0000, 32'd0,  1'b0, 1'b1, 32'h0, 32'h0,         1'b0, 0, 0, 0};
        tbl[3] = '{32'h0004_0000, 32'd3,  1'b1, 1'b1, 32'h0, 32'hC0DE_0000, 1'b0, 4, 0, 3};
        tbl[4] = '{32'h0000_0401, 32'd7,  1'b0, 1'b0, 32'h0, 32'h0,         1'b1, 0, 0, 0};
        tbl[5] = '{32'h0200_0003, 32'd2,  1'b0, 1'b1, 32'h0, 32'h0BAD_0000, 1'b0, 512, 3, 2};

        arst_n      = 1'b0;
        start       = 1'b0;
        run_len     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_wen", 32'({bus.wen_ext, bus.wen_ext_2}), 32'd0);
        check("rst_addr", bus.addr_ext | bus.addr_ext_2, 32'd0);
        check("rst_flags", 32'({cpu_enable, busy, done, error}), 32'd0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_session(tbl[i]);

        // Reset in the middle of RUN, after checking that start is ignored while busy.
        start   = 1'b1;
        run_len = 32'd50;
        @(posedge clk); #1;
        start = 1'b0;
        w1 = 32'hAAAA_0001;
        w2 = 32'h5555_0002;
        send_word(32'h0001_0001);
        send_word(w1);
        exp_i.push_back('{32'h0, w1});
        send_word(w2);
        exp_d.push_back('{32'h0, w2});
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0001_0001 + w1 + w2);
`endif
        cyc = 0;
        while (!cpu_enable && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("run_enable", 32'(cpu_enable), 32'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ignored_enable", 32'(cpu_enable), 32'd1);
        check("start_ignored_busy", 32'(busy), 32'd1);
        compare_writes();
        #2 arst_n = 1'b0;
        #1;
        check("midrun_rst_enable", 32'(cpu_enable), 32'd0);
        check("midrun_rst_flags", 32'({busy, done, error}), 32'd0);
        check("midrun_rst_wen", 32'({bus.wen_ext, bus.wen_ext_2}), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        run_session(tbl[0]);

`ifdef LOADER_CHECKSUM_EN
        run_session('{32'h0001_0000, 32'd4, 1'b0, 1'b1, 32'h0,         32'h5, 1'b0, 1, 0, 4});
        run_session('{32'h0001_0000, 32'd4, 1'b0, 1'b1, 32'h0001_0005, 32'h5, 1'b1, 1, 0, 0});
`endif

        check("enable_strobe_overlap", 32'(overlap_total), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot and run sequencer that sits directly upstream of the cpu top. It accepts a valid/ready word stream carrying a program image and writes it into instruction and data memory through the cpu external memory ports. It then holds cpu enable high for a programmed number of cycles and reports completion. Testbench or host logic drives the stream; the cpu core itself is unchanged.

Parameters:
DATA_W, 32, stream and memory word width
IMEM_DEPTH, 512, maximum instruction words (matches 9-bit imem)
DMEM_DEPTH, 1024, maximum data words (matches 10-bit dmem)
ADDR_STRIDE, 4, byte increment between consecutive words on addr_ext/addr_ext_2

Ports:
clk  in  1  main clock
arst_n  in  1  asynchronous active-low reset
start  in  1  begin a load/run session (level sampled in IDLE, DONE, ERR)
run_len  in  32  number of cycles cpu_enable is held high; sampled with start
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  loader accepts word this cycle
addr_ext  out  32  imem external address
wen_ext  out  1  imem external write enable
ren_ext  out  1  imem external read enable, tied 0
wdata_ext  out  DATA_W  imem external write data
addr_ext_2  out  32  dmem external address
wen_ext_2  out  1  dmem external write enable
ren_ext_2  out  1  dmem external read enable, tied 0
wdata_ext_2  out  DATA_W  dmem external write data
cpu_enable  out  1  drives cpu enable
busy  out  1  state not IDLE/DONE/ERR
done  out  1  run completed (sticky until next start)
error  out  1  header or checksum fault (sticky until next start)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-session drops cpu_enable and any write strobe immediately (async); no partial recovery.
- States: IDLE, HDR, LOAD_I, LOAD_D, [CHK], RUN, DONE, ERR.
- IDLE/DONE/ERR + start=1 -> HDR; run_len latched; done, error cleared.
- Handshake: word transfers when s_valid && s_ready. s_ready=1 only in HDR, LOAD_I, LOAD_D, CHK.
- HDR: header word: [31:16]=n_i (imem words), [15:0]=n_d (dmem words). n_i>IMEM_DEPTH or n_d>DMEM_DEPTH -> ERR. Else -> LOAD_I if n_i>0, else LOAD_D if n_d>0, else CHK/RUN.
- LOAD_I: k-th accepted word (k from 0) produces, on the following cycle, wen_ext=1 for exactly one cycle, addr_ext=k*ADDR_STRIDE, wdata_ext=word. After word n_i-1 -> LOAD_D (or CHK/RUN if n_d=0).
- LOAD_D: same rule on the _2 port, addresses restart at 0.
- Write latency: 1 cycle after handshake; back-to-back handshakes give back-to-back write strobes. Addresses and data hold their last value when strobes are low.
- Stalls (s_valid=0) hold state and counters; no strobe issued.
- RUN: entered one cycle after the last write strobe has issued. cpu_enable=1 for exactly run_len cycles, counted by a 32-bit down counter; run_len=0 -> DONE without asserting cpu_enable. Then DONE: done=1.
- ERR: error=1, cpu_enable never asserted, s_ready=0.
- start outside IDLE/DONE/ERR is ignored.

Optional Feature:
LOADER_CHECKSUM_EN defined: after the payload, state CHK accepts one trailer word. It must equal the mod-2^32 sum of header plus all payload words. Match -> RUN; mismatch -> ERR. Undefined: no CHK state, no trailer, payload end goes straight to RUN.

Decomposition:
- Shared package: state enumeration, header field positions (N_I_MSB/LSB, N_D_MSB/LSB), ADDR_STRIDE default.
- One sub-module natural: loader_word_counter (load/clear, increment on handshake, terminal-count flag), instantiated for the word index and reused for the run counter.
- Write-strobe output registers use the existing reg_arstn_en flop.

Test Plan:
- Header 0x0003_0002, words I0..I2, D0..D1, run_len=10 -> wen_ext at addr 0,4,8 with I0..I2; wen_ext_2 at addr 0,4 with D0..D1; cpu_enable high exactly 10 cycles; done=1.
- Header 0x0201_0000 (n_i=513) -> error=1, no write strobes, cpu_enable stays 0.
- Header 0x0000_0000, run_len=0 -> done=1 within 3 cycles of header handshake; no strobes, cpu_enable never 1.
- s_valid toggled 1/0 during 4-word imem load -> exactly 4 strobes, addresses contiguous 0..12, no duplicates.
- arst_n pulsed low mid-RUN -> cpu_enable 0 immediately; busy=0, done=0; a fresh start then loads correctly.
- LOADER_CHECKSUM_EN: header 0x0001_0000, word 0x5, trailer 0x0001_0005 -> RUN; trailer 0x0 -> error=1.
